// File: rtl/except_ctrl_pkg.sv
// Shared CP0 / exception types for the MEM-stage exception initiator.
//   - EXCCODE_* : MIPS exception codes
//   - cp0_regs_t: status, cause and EPC as seen by the pipeline
//   - cp0_wreq_t: WB-stage CP0 write (used for EPC forwarding)
//   - except_req_t: request issued to cp0
//   - mem_ex_t  : per-instruction fault flags, MSB first:
//                 {if_adel, id_ri, id_sys, id_bp, ex_ov, mem_adel, mem_ades}
//   - except_state_e: exception FSM state, exported for debug
package except_ctrl_pkg;

    localparam logic [4:0] EXCCODE_INT  = 5'd0;
    localparam logic [4:0] EXCCODE_ADEL = 5'd4;
    localparam logic [4:0] EXCCODE_ADES = 5'd5;
    localparam logic [4:0] EXCCODE_SYS  = 5'd8;
    localparam logic [4:0] EXCCODE_BP   = 5'd9;
    localparam logic [4:0] EXCCODE_RI   = 5'd10;
    localparam logic [4:0] EXCCODE_OV   = 5'd12;

    localparam logic [4:0] CP0_EPC_ADDR = 5'd14;
    localparam logic [2:0] CP0_EPC_SEL  = 3'd0;

    typedef struct packed {
        logic       bev;
        logic [7:0] im;
        logic       erl;
        logic       exl;
        logic       ie;
    } cp0_status_t;

    typedef struct packed {
        logic       bd;
        logic [7:0] ip;
        logic [4:0] exccode;
    } cp0_cause_t;

    typedef struct packed {
        cp0_status_t status;
        cp0_cause_t  cause;
        logic [31:0] epc;
    } cp0_regs_t;

    typedef struct packed {
        logic        we;
        logic [4:0]  waddr;
        logic [2:0]  wsel;
        logic [31:0] wrdata;
    } cp0_wreq_t;

    typedef struct packed {
        logic        valid;
        logic [4:0]  code;
        logic [31:0] pc;
        logic        delayslot;
        logic        eret;
        logic [31:0] extra;
    } except_req_t;

    typedef struct packed {
        logic if_adel, id_ri, id_sys, id_bp, ex_ov, mem_adel, mem_ades;
    } mem_ex_t;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_FLUSH = 1'b1
    } except_state_e;

    // An interrupt is pending when globally enabled, not already inside an
    // exception/error handler, and at least one unmasked IP bit is set.
    function automatic logic int_pending(input cp0_regs_t r);
        return r.status.ie & ~r.status.exl & ~r.status.erl &
               (|(r.cause.ip & r.status.im));
    endfunction

endpackage

// File: rtl/except_prio.sv
// Combinational exception priority encoder.
//   int_pend  : interrupt pending (highest priority)
//   ex        : per-instruction fault flags
//   mem_pc    : PC of the MEM instruction (extra for fetch AdEL)
//   mem_vaddr : data address (extra for data AdEL/AdES)
//   hit       : an interrupt or fault is present
//   code      : selected exception code (0 when nothing hits)
//   extra     : bad address for address errors, otherwise 0
module except_prio
    import except_ctrl_pkg::*;
(
    input  logic        int_pend,
    input  mem_ex_t     ex,
    input  logic [31:0] mem_pc,
    input  logic [31:0] mem_vaddr,
    output logic        hit,
    output logic [4:0]  code,
    output logic [31:0] extra
);

    always_comb begin
        hit   = 1'b1;
        code  = EXCCODE_INT;
        extra = '0;
        if (int_pend) begin
            code = EXCCODE_INT;
        end else if (ex.if_adel) begin
            code  = EXCCODE_ADEL;
            extra = mem_pc;
        end else if (ex.id_ri) begin
            code = EXCCODE_RI;
        end else if (ex.id_sys) begin
            code = EXCCODE_SYS;
        end else if (ex.id_bp) begin
            code = EXCCODE_BP;
        end else if (ex.ex_ov) begin
            code = EXCCODE_OV;
        end else if (ex.mem_adel) begin
            code  = EXCCODE_ADEL;
            extra = mem_vaddr;
        end else if (ex.mem_ades) begin
            code  = EXCCODE_ADES;
            extra = mem_vaddr;
        end else begin
            hit = 1'b0;
        end
    end

endmodule

// File: rtl/except_ctrl.sv
// MEM-stage exception initiator.
// Turns faults / pending interrupts / ERET of the committing MEM instruction
// into one except_req to cp0, then issues a registered one-cycle flush with
// the redirect target and ignores MEM for FLUSH_CYCLES cycles.
// Ports:
//   clk, rst (sync, active-low)
//   mem_valid/mem_stall/mem_pc/mem_delayslot/mem_eret/mem_ex/mem_vaddr : MEM stage
//   cp0_regs  : current CP0 state;  cp0_wreq : WB-stage CP0 write (EPC forward)
//   hw_int    : raw interrupt lines
//   except_req (comb), interrupt_flag ([7:2]=hw lines), flush, redirect_pc (registered)
//   dbg_state : exception FSM state
// Build option: EXCEPT_INT_SYNC_EN adds a 2-flop synchroniser on hw_int.
module except_ctrl
    import except_ctrl_pkg::*;
#(
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter logic [31:0] VEC_BEV      = 32'hBFC00380,
    parameter logic [31:0] VEC_NORM     = 32'h80000180
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          mem_valid,
    input  logic          mem_stall,
    input  logic [31:0]   mem_pc,
    input  logic          mem_delayslot,
    input  logic          mem_eret,
    input  mem_ex_t       mem_ex,
    input  logic [31:0]   mem_vaddr,
    input  cp0_regs_t     cp0_regs,
    input  cp0_wreq_t     cp0_wreq,
    input  logic [5:0]    hw_int,
    output except_req_t   except_req,
    output logic [7:0]    interrupt_flag,
    output logic          flush,
    output logic [31:0]   redirect_pc,
    output except_state_e dbg_state
);

    localparam logic [2:0] CNT_LOAD = 3'(FLUSH_CYCLES - 1);

    except_state_e state_q, state_d;
    logic [2:0]    cnt_q, cnt_d;
    logic          flush_q, flush_d;
    logic [31:0]   redirect_q, redirect_d;

    logic        int_pend;
    logic        commit;
    logic        prio_hit;
    logic [4:0]  prio_code;
    logic [31:0] prio_extra;
    logic        req_valid;
    logic        is_eret;
    logic [31:0] epc_fwd;
    logic [31:0] target;

    // cause.bd / cause.exccode are cp0's own bookkeeping, not inputs here.
    logic unused_cause;
    assign unused_cause = ^{cp0_regs.cause.bd, cp0_regs.cause.exccode};

    assign int_pend = int_pending(cp0_regs);
    // FLUSH state blocks commit, which also blocks interrupts from attaching.
    assign commit   = mem_valid & ~mem_stall & (state_q == ST_IDLE);

    except_prio u_prio (
        .int_pend  (int_pend),
        .ex        (mem_ex),
        .mem_pc    (mem_pc),
        .mem_vaddr (mem_vaddr),
        .hit       (prio_hit),
        .code      (prio_code),
        .extra     (prio_extra)
    );

    // rst gates valid so nothing reaches cp0 while the block is in reset.
    assign req_valid = commit & (prio_hit | mem_eret) & rst;
    // Any interrupt or fault on an ERET wins; the ERET itself is dropped.
    assign is_eret   = mem_eret & ~prio_hit;

    // An EPC write sitting in WB this cycle is newer than cp0_regs.epc.
    assign epc_fwd = (cp0_wreq.we && cp0_wreq.wsel == CP0_EPC_SEL &&
                      cp0_wreq.waddr == CP0_EPC_ADDR) ? cp0_wreq.wrdata : cp0_regs.epc;
    assign target  = is_eret ? epc_fwd : (cp0_regs.status.bev ? VEC_BEV : VEC_NORM);

    always_comb begin
        except_req           = '0;
        except_req.valid     = req_valid;
        except_req.code      = prio_code;
        except_req.pc        = mem_pc;
        except_req.delayslot = mem_delayslot;
        except_req.eret      = is_eret;
        except_req.extra     = prio_extra;
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        flush_d    = 1'b0;
        redirect_d = redirect_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    state_d    = ST_FLUSH;
                    cnt_d      = CNT_LOAD;
                    flush_d    = 1'b1;
                    redirect_d = target;
                end
            end
            ST_FLUSH: begin
                if (cnt_q == 3'd0) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            flush_q    <= 1'b0;
            redirect_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            flush_q    <= flush_d;
            redirect_q <= redirect_d;
        end
    end

    assign flush       = flush_q;
    assign redirect_pc = redirect_q;
    assign dbg_state   = state_q;

`ifdef EXCEPT_INT_SYNC_EN
    logic [5:0] sync1_q, sync1_d;
    logic [5:0] sync2_q, sync2_d;

    assign sync1_d = hw_int;
    assign sync2_d = sync1_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
        end
    end

    assign interrupt_flag = {sync2_q, 2'b00};
`else
    assign interrupt_flag = {hw_int, 2'b00};
`endif

endmodule
